// File: rtl/riscv_exec_pkg.sv
// riscv_exec_pkg
// Shared types and helpers for the RV32 execute stage.
//   XLEN, REG_ADDR_W : datapath width and register index width
//   exec_state_t     : execute-stage FSM states
//   sext12()         : sign-extends a raw 12-bit I-type immediate to XLEN
package riscv_exec_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE,
        SHIFT
    } exec_state_t;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] raw);
        return {{(XLEN-12){raw[11]}}, raw};
    endfunction

endpackage

// File: rtl/imm_alu.sv
// imm_alu
// Purely combinational immediate ALU: computes the I-type result from the
// operand, the sign-extended immediate and the op code.
//   alu_control in  5     op code (`ADDI ... `ANDI)
//   src         in  XLEN  first operand (already forwarded)
//   simm        in  XLEN  sign-extended immediate; simm[4:0] is the shift amount
//   result      out XLEN  ALU result, 0 for unsupported ops
//   op_valid    out 1     low for an unsupported op code
`include "processor_defines.sv"

module imm_alu
    import riscv_exec_pkg::*;
(
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] src,
    input  logic [XLEN-1:0] simm,
    output logic [XLEN-1:0] result,
    output logic            op_valid
);

    always_comb begin
        result   = '0;
        op_valid = 1'b1;
        case (alu_control)
            `ADDI:  result = src + simm;
            `SLTI:  result = {{(XLEN-1){1'b0}}, ($signed(src) < $signed(simm))};
            `SLTIU: result = {{(XLEN-1){1'b0}}, (src < simm)};
            `XORI:  result = src ^ simm;
            `ORI:   result = src | simm;
            `ANDI:  result = src & simm;
            `SLLI:  result = src << simm[4:0];
            `SRAI:  result = $unsigned($signed(src) >>> simm[4:0]);
            default: op_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/processor_defines.sv
// processor_defines.sv
// Op-code macros for the immediate ALU instructions, shared by the decode and
// execute stages. Any 5-bit alu_control value not listed here is treated as an
// unsupported op by the execute stage.
`ifndef PROCESSOR_DEFINES_SV
`define PROCESSOR_DEFINES_SV

`define ADDI  5'd1
`define SLLI  5'd2
`define SLTI  5'd3
`define SLTIU 5'd4
`define XORI  5'd5
`define SRAI  5'd6
`define ORI   5'd7
`define ANDI  5'd8

`endif

// File: rtl/imm_exec_stage.sv
// imm_exec_stage
// Execute stage for RV32 I-type ALU instructions. Reads rs1 (with forwarding
// from the registered writeback), computes the result and presents a
// registered writeback to the register file.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake; transfer = in_valid & in_ready
//   rs1, rd, imm         decoded operand fields (imm raw 12 bit)
//   alu_control          op code from processor_defines.sv
//   rf_raddr/rf_rdata    combinational register-file read port
//   wb_valid, wb_we      retire pulse and register write enable
//   wb_rd, wb_data       writeback destination and value (held between retires)
//   busy                 multi-cycle shift in flight
// Build option: define SERIAL_SHIFT_EN to run SLLI/SRAI through a 1-bit/cycle
// serial shifter (latency shamt+1); otherwise shifts use the barrel shifter.
`include "processor_defines.sv"

module imm_exec_stage
    import riscv_exec_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [11:0]           imm,
    input  logic [4:0]            alu_control,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]       rf_rdata,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  busy
);

    exec_state_t           state_q, state_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_we_q, wb_we_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;

    logic [XLEN-1:0]       src, simm, alu_result;
    logic                  alu_op_valid, accept, go_serial;

    assign rf_raddr = rs1;
    assign simm     = sext12(imm);
    assign accept   = in_valid & in_ready;

    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

    // The regfile write for the retiring result lands on the same edge that
    // accepts the next instruction, so that result must be bypassed.
    always_comb begin
        if (rs1 == '0)
            src = '0;
        else if (wb_we_q && (wb_rd_q == rs1))
            src = wb_data_q;
        else
            src = rf_rdata;
    end

    imm_alu u_imm_alu (
        .alu_control (alu_control),
        .src         (src),
        .simm        (simm),
        .result      (alu_result),
        .op_valid    (alu_op_valid)
    );

`ifdef SERIAL_SHIFT_EN
    logic [XLEN-1:0]       shift_val_q, shift_val_d, shift_next;
    logic [4:0]            count_q, count_d;
    logic                  shift_left_q, shift_left_d;
    logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;

    // A zero shift amount finishes in one cycle through the ALU path.
    assign go_serial  = accept && ((alu_control == `SLLI) || (alu_control == `SRAI))
                        && (imm[4:0] != 5'd0);
    assign shift_next = shift_left_q ? {shift_val_q[XLEN-2:0], 1'b0}
                                     : {shift_val_q[XLEN-1], shift_val_q[XLEN-1:1]};
`else
    assign go_serial  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
`ifdef SERIAL_SHIFT_EN
            shift_val_q  <= '0;
            count_q      <= '0;
            shift_left_q <= 1'b0;
            pend_rd_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
`ifdef SERIAL_SHIFT_EN
            shift_val_q  <= shift_val_d;
            count_q      <= count_d;
            shift_left_q <= shift_left_d;
            pend_rd_q    <= pend_rd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go_serial)
                    state_d = SHIFT;
            end
            SHIFT: begin
`ifdef SERIAL_SHIFT_EN
                if (count_q == 5'd1)
                    state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
`ifdef SERIAL_SHIFT_EN
        busy     = (state_q == SHIFT);
`else
        busy     = 1'b0;
`endif
    end

    // wb_valid/wb_we default low so they pulse for exactly one cycle;
    // wb_rd/wb_data hold their last retired value.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
`ifdef SERIAL_SHIFT_EN
        shift_val_d  = shift_val_q;
        count_d      = count_q;
        shift_left_d = shift_left_q;
        pend_rd_d    = pend_rd_q;

        if (go_serial) begin
            shift_val_d  = src;
            count_d      = imm[4:0];
            shift_left_d = (alu_control == `SLLI);
            pend_rd_d    = rd;
        end

        // The final shift step retires directly into the writeback registers.
        if (state_q == SHIFT) begin
            shift_val_d = shift_next;
            count_d     = count_q - 5'd1;
            if (count_q == 5'd1) begin
                wb_valid_d = 1'b1;
                wb_we_d    = (pend_rd_q != '0);
                wb_rd_d    = pend_rd_q;
                wb_data_d  = shift_next;
            end
        end
`endif
        if (accept && !go_serial) begin
            wb_valid_d = 1'b1;
            wb_we_d    = alu_op_valid && (rd != '0);
            wb_rd_d    = rd;
            wb_data_d  = alu_result;
        end
    end

endmodule

// File: tb/tb_imm_exec_stage.sv
// tb_imm_exec_stage
// Self-checking bench for imm_exec_stage: directed cases followed by a random
// instruction stream compared against an arithmetic reference model and an
// architectural register-file image kept in the bench.
`include "processor_defines.sv"

module tb_imm_exec_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [4:0]  alu_control;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    logic [31:0] regs [32];
    logic [31:0] model_regs [32];
    logic        load_en;
    logic [4:0]  load_idx;
    logic [31:0] load_val;

    int tests_run;
    int tests_failed;

    imm_exec_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rs1         (rs1),
        .rd          (rd),
        .imm         (imm),
        .alu_control (alu_control),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file seen by the DUT: bench preloads take priority over writeback.
    assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : regs[rf_raddr];

    always @(posedge clk) begin
        if (load_en)
            regs[load_idx] <= load_val;
        else if (wb_we && (wb_rd != 5'd0))
            regs[wb_rd] <= wb_data;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Result computed from the instruction definitions with wide integer arithmetic.
    task automatic refModel(input logic [4:0] op, input logic [31:0] srcv, input logic [11:0] im,
                            output logic [31:0] data, output logic ok);
        longint u, s, si, pw, q;
        int     sh;
        u  = longint'({32'd0, srcv});
        s  = longint'($signed(srcv));
        si = longint'($signed(im));
        sh = int'(im[4:0]);
        pw = longint'(1) << sh;
        ok = 1'b1;
        case (op)
            `ADDI:  q = (u + si) & 64'hFFFF_FFFF;
            `SLTI:  q = (s < si) ? 1 : 0;
            `SLTIU: q = (u < (si & 64'hFFFF_FFFF)) ? 1 : 0;
            `XORI:  q = u ^ (si & 64'hFFFF_FFFF);
            `ORI:   q = u | (si & 64'hFFFF_FFFF);
            `ANDI:  q = u & si;
            `SLLI:  q = (u * pw) & 64'hFFFF_FFFF;
            `SRAI:  q = (s >= 0) ? s / pw : -(((-s) + pw - 1) / pw);
            default: begin
                q  = 0;
                ok = 1'b0;
            end
        endcase
        data = q[31:0];
    endtask

    task automatic setReg(input logic [4:0] idx, input logic [31:0] val);
        load_en  = 1'b1;
        load_idx = idx;
        load_val = val;
        model_regs[idx] = val;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Called at a negedge; drives one instruction and returns the expected result.
    task automatic applyStimulus(input logic [4:0] op, input logic [4:0] src_idx, input logic [4:0] dst_idx,
                                 input logic [11:0] im, output int lat, output logic [31:0] data,
                                 output logic we);
        logic ok;
        check("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
        alu_control = op;
        rs1         = src_idx;
        rd          = dst_idx;
        imm         = im;
        in_valid    = 1'b1;
        refModel(op, model_regs[src_idx], im, data, ok);
        we = ok && (dst_idx != 5'd0);
`ifdef SERIAL_SHIFT_EN
        if (((op == `SLLI) || (op == `SRAI)) && (im[4:0] != 5'd0))
            lat = int'(im[4:0]) + 1;
        else
            lat = 1;
`else
        lat = 1;
`endif
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        rs1         = 5'($urandom);
        rd          = 5'($urandom);
        imm         = 12'($urandom);
        alu_control = 5'($urandom);
    endtask

    // Waits out the latency, checks the stall cycles and the retire cycle,
    // then commits the result into the architectural image. Ends on a negedge.
    task automatic checkOutput(input string tag, input int lat, input logic [4:0] exp_rd,
                               input logic [31:0] exp_data, input logic exp_we);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                check({tag, ".stall_wb_valid"}, {31'd0, wb_valid}, 32'd0);
                check({tag, ".stall_in_ready"}, {31'd0, in_ready}, 32'd0);
                check({tag, ".stall_busy"}, {31'd0, busy}, 32'd1);
            end else begin
                check({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
                check({tag, ".wb_we"}, {31'd0, wb_we}, {31'd0, exp_we});
                check({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, exp_rd});
                check({tag, ".wb_data"}, wb_data, exp_data);
                check({tag, ".busy"}, {31'd0, busy}, 32'd0);
            end
        end
        if (exp_we)
            model_regs[exp_rd] = exp_data;
    endtask

    initial begin
        int          lat;
        logic [31:0] d;
        logic        w;
        logic [4:0]  ops [9];
        logic [4:0]  op, r1, rdst, last_rd;
        logic [11:0] im;
        logic        seen;

        ops = '{`ADDI, `SLLI, `SLTI, `SLTIU, `XORI, `SRAI, `ORI, `ANDI, 5'd0};
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        rs1          = '0;
        rd           = '0;
        imm          = '0;
        alu_control  = '0;
        load_en      = 1'b0;
        load_idx     = '0;
        load_val     = '0;
        model_regs[0] = 32'd0;

        // Preload the register file while reset is held.
        @(negedge clk);
        for (int i = 1; i < 32; i++)
            setReg(5'(i), $urandom);
        load_idx = 5'd0;
        load_val = 32'd0;
        @(posedge clk);
        @(negedge clk);
        setReg(5'd0, 32'd0);

        check("reset.wb_valid", {31'd0, wb_valid}, 32'd0);
        check("reset.wb_we", {31'd0, wb_we}, 32'd0);
        check("reset.wb_rd", {27'd0, wb_rd}, 32'd0);
        check("reset.wb_data", wb_data, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);

        // ADDI with a negative immediate, then the hold behaviour.
        setReg(5'd2, 32'h0000_0010);
        applyStimulus(`ADDI, 5'd2, 5'd1, 12'hFFF, lat, d, w);
        checkOutput("addi_neg", 1, 5'd1, 32'h0000_000F, 1'b1);
        @(negedge clk);
        check("hold.wb_valid", {31'd0, wb_valid}, 32'd0);
        check("hold.wb_we", {31'd0, wb_we}, 32'd0);
        check("hold.wb_rd", {27'd0, wb_rd}, 32'd1);
        check("hold.wb_data", wb_data, 32'h0000_000F);

        // Unsigned vs signed compare against an all-ones immediate.
        setReg(5'd5, 32'd5);
        applyStimulus(`SLTIU, 5'd5, 5'd7, 12'hFFF, lat, d, w);
        checkOutput("sltiu", 1, 5'd7, 32'd1, 1'b1);
        applyStimulus(`SLTI, 5'd5, 5'd8, 12'hFFF, lat, d, w);
        checkOutput("slti", 1, 5'd8, 32'd0, 1'b1);

        // Arithmetic right shift by 4.
        setReg(5'd6, 32'h8000_0000);
        applyStimulus(`SRAI, 5'd6, 5'd9, 12'h004, lat, d, w);
`ifdef SERIAL_SHIFT_EN
        checkOutput("srai4", 5, 5'd9, 32'hF800_0000, 1'b1);
`else
        checkOutput("srai4", 1, 5'd9, 32'hF800_0000, 1'b1);
`endif

        // Back-to-back dependency: second read of x3 needs the bypass.
        applyStimulus(`ADDI, 5'd0, 5'd3, 12'd7, lat, d, w);
        checkOutput("b2b_first", 1, 5'd3, 32'd7, 1'b1);
        applyStimulus(`ADDI, 5'd3, 5'd4, 12'd1, lat, d, w);
        checkOutput("b2b_second", 1, 5'd4, 32'd8, 1'b1);

        // Writes to x0 retire without a register write.
        applyStimulus(`ADDI, 5'd4, 5'd0, 12'd3, lat, d, w);
        checkOutput("addi_x0", 1, 5'd0, 32'd11, 1'b0);

        // Unsupported op code.
        applyStimulus(5'd31, 5'd4, 5'd10, 12'h123, lat, d, w);
        checkOutput("bad_op", 1, 5'd10, 32'd0, 1'b0);

`ifdef SERIAL_SHIFT_EN
        // Reset in the middle of a long serial shift aborts it.
        applyStimulus(`SRAI, 5'd6, 5'd11, 12'h01F, lat, d, w);
        repeat (3) @(negedge clk);
        check("abort.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.wb_valid", {31'd0, wb_valid}, 32'd0);
        check("abort.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("abort.in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            seen = seen | wb_valid;
        end
        check("abort.no_retire", {31'd0, seen}, 32'd0);
`endif

        // Random stream; a quarter of sources reuse the previous destination.
        last_rd = 5'd1;
        for (int n = 0; n < 80; n++) begin
            op   = ops[$urandom_range(0, 8)];
            r1   = ($urandom_range(0, 3) == 0) ? last_rd : 5'($urandom_range(0, 31));
            rdst = 5'($urandom_range(0, 31));
            im   = 12'($urandom);
            applyStimulus(op, r1, rdst, im, lat, d, w);
            checkOutput($sformatf("rand%0d", n), lat, rdst, d, w);
            last_rd = rdst;
        end

        // Architectural state must match the model after the last write lands.
        repeat (2) @(negedge clk);
        for (int i = 1; i < 32; i++)
            check($sformatf("regfile_x%0d", i), regs[i], model_regs[i]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
